// File: rtl/onewire_bus_responder.sv
// Single-wire serial byte receiver: start/8 data LSB-first/stop framing on an open-drain line.
// Define ONEWIRE_ACK_EN to add an active-low acknowledge pulse after each good frame.
`timescale 1ns/1ps
module onewire_bus_responder #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        bus_line,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
`ifdef ONEWIRE_ACK_EN
      ACK,
`endif
      WAIT_IDLE
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic [7:0]    data_reg, data_next;
   logic          valid_reg, valid_next;
   logic          err_reg, err_next;
   logic [1:0]    sync_reg;
   logic          prev_reg;
`ifdef ONEWIRE_ACK_EN
   logic          stop_ok_reg, stop_ok_next;
   logic          drive_reg, drive_next;
`endif

   // Anything that is not a solid 0 (Z or X) counts as the pulled-up idle level.
   logic line_raw;
   logic line_s;
   logic fall;
   assign line_raw = (bus_line !== 1'b0);
   assign line_s   = sync_reg[1];
   // prev_reg resets to 0, so a line held low through reset never looks like an edge.
   assign fall     = prev_reg & ~line_s;

`ifdef ONEWIRE_ACK_EN
   assign bus_line = drive_reg ? 1'b0 : 1'bz;
`else
   assign bus_line = 1'bz;
`endif

   assign data_out   = data_reg;
   assign data_valid = valid_reg;
   assign frame_err  = err_reg;
   assign busy       = (state_reg != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg    <= 2'b00;
         prev_reg    <= 1'b0;
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_reg     <= 3'd0;
         shift_reg   <= 8'h00;
         data_reg    <= 8'h00;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
`ifdef ONEWIRE_ACK_EN
         stop_ok_reg <= 1'b0;
         drive_reg   <= 1'b0;
`endif
      end else begin
         sync_reg    <= {sync_reg[0], line_raw};
         prev_reg    <= line_s;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         err_reg     <= err_next;
`ifdef ONEWIRE_ACK_EN
         stop_ok_reg <= stop_ok_next;
         drive_reg   <= drive_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      err_next     = 1'b0;
`ifdef ONEWIRE_ACK_EN
      stop_ok_next = stop_ok_reg;
      drive_next   = drive_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next   = '0;
               bit_next   = 3'd0;
               state_next = line_s ? IDLE : DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               shift_next = {line_s, shift_reg[7:1]};
               if (bit_reg == 3'd7) state_next = STOP;
               else                 bit_next   = bit_reg + 3'd1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         STOP: begin
`ifdef ONEWIRE_ACK_EN
            // After a good stop sample, run out the second half of the stop bit before acking.
            if (stop_ok_reg) begin
               if (cnt_reg == HALF_LAST) begin
                  state_next   = ACK;
                  cnt_next     = '0;
                  stop_ok_next = 1'b0;
                  drive_next   = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end else
`endif
            if (cnt_reg == LAST) begin
               cnt_next = '0;
               if (line_s) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
`ifdef ONEWIRE_ACK_EN
                  stop_ok_next = 1'b1;
`else
                  state_next = WAIT_IDLE;
`endif
               end else begin
                  err_next   = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`ifdef ONEWIRE_ACK_EN
         ACK: begin
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               drive_next = 1'b0;
               state_next = WAIT_IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`endif
         WAIT_IDLE: begin
            if (!line_s) begin
               cnt_next = '0;
            end else if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_onewire_bus_responder.sv
// Directed bench for onewire_bus_responder at 16 clocks per bit; bench line is open-drain with pull-up.
`timescale 1ns/1ps
module tb_onewire_bus_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_low = 1'b0;
   wire        bus_line;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   assign bus_line = tb_low ? 1'b0 : 1'bz;
   pullup (bus_line);

   onewire_bus_responder #(.CLKS_PER_BIT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_line   (bus_line),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int stop_cyc = 0;

   int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, long_cnt = 0;
   int         rl_cnt = 0, ack_start_cyc = 0;
   logic       dv_prev = 1'b0, fe_prev = 1'b0, rl_prev = 1'b0;
   logic [7:0] last_dv = 8'h00, prev_dv = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Observes pulses and any low level on the line that the bench is not causing.
   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt  <= dv_cnt + 1;
         last_dv <= data_out;
         prev_dv <= last_dv;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (data_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((data_valid && dv_prev) || (frame_err && fe_prev)) long_cnt <= long_cnt + 1;
      if ((bus_line === 1'b0) && !tb_low) begin
         rl_cnt <= rl_cnt + 1;
         if (!rl_prev) ack_start_cyc <= cyc;
      end
      rl_prev <= (bus_line === 1'b0) && !tb_low;
      dv_prev <= data_valid;
      fe_prev <= frame_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      $display("frame 0x%02h stop=%0d", b, stop);
      tb_low = 1'b1;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         tb_low = ~b[i];
         tick(16);
      end
      tb_low   = ~stop;
      stop_cyc = cyc;
      tick(16);
      tb_low = 1'b0;
   endtask

   task automatic wait_not_busy(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset;
      tb_low = 1'b1;
      rst    = 1'b1;
      tick(3);
      vectors++;
      if ({data_out, data_valid, frame_err, busy} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_outputs: got do=%h dv=%b fe=%b busy=%b want 00/0/0/0",
                  data_out, data_valid, frame_err, busy);
      end
      rst = 1'b0;
      tick(40);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL low_after_reset: busy=%b want 0", busy);
      end
      tb_low = 1'b0;
      tick(20);
      vectors++;
      if (busy !== 1'b0 || dv_cnt !== 0 || fe_cnt !== 0) begin
         miscompares++;
         $display("FAIL release_after_reset: busy=%b dv=%0d fe=%0d want 0/0/0", busy, dv_cnt, fe_cnt);
      end
   endtask

   task automatic test_frame_a5;
      int dv0 = dv_cnt, fe0 = fe_cnt, rl0 = rl_cnt;
      send_frame(8'hA5, 1'b1);
      wait_not_busy(100);
      vectors++;
      if (dv_cnt - dv0 !== 1 || last_dv !== 8'hA5) begin
         miscompares++;
         $display("FAIL a5_valid: pulses=%0d data=%h want 1/a5", dv_cnt - dv0, last_dv);
      end
      vectors++;
      if (data_out !== 8'hA5 || fe_cnt - fe0 !== 0) begin
         miscompares++;
         $display("FAIL a5_hold: data_out=%h fe=%0d want a5/0", data_out, fe_cnt - fe0);
      end
`ifdef ONEWIRE_ACK_EN
      vectors++;
      if (rl_cnt - rl0 !== 16) begin
         miscompares++;
         $display("FAIL a5_ack_len: low cycles=%0d want 16", rl_cnt - rl0);
      end
      vectors++;
      if (ack_start_cyc - stop_cyc !== 19) begin
         miscompares++;
         $display("FAIL a5_ack_start: offset=%0d want 19", ack_start_cyc - stop_cyc);
      end
`else
      vectors++;
      if (rl_cnt - rl0 !== 0) begin
         miscompares++;
         $display("FAIL a5_no_drive: low cycles=%0d want 0", rl_cnt - rl0);
      end
`endif
   endtask

   task automatic test_glitch;
      int   dv0 = dv_cnt, fe0 = fe_cnt, rl0 = rl_cnt;
      logic seen = 1'b0;
      $display("glitch 4 cycles");
      tb_low = 1'b1;
      tick(4);
      tb_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (busy) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_fsm: seen_busy=%b busy=%b want 1/0", seen, busy);
      end
      vectors++;
      if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0 || rl_cnt - rl0 !== 0) begin
         miscompares++;
         $display("FAIL glitch_quiet: dv=%0d fe=%0d low=%0d want 0/0/0",
                  dv_cnt - dv0, fe_cnt - fe0, rl_cnt - rl0);
      end
   endtask

   task automatic test_frame_err;
      int dv0 = dv_cnt, fe0 = fe_cnt, rl0 = rl_cnt;
      send_frame(8'h3C, 1'b0);
      tick(12);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL ferr_busy_hold: busy=%b want 1", busy);
      end
      wait_not_busy(40);
      vectors++;
      if (fe_cnt - fe0 !== 1 || dv_cnt - dv0 !== 0) begin
         miscompares++;
         $display("FAIL ferr_pulse: fe=%0d dv=%0d want 1/0", fe_cnt - fe0, dv_cnt - dv0);
      end
      vectors++;
      if (data_out !== 8'hA5 || rl_cnt - rl0 !== 0) begin
         miscompares++;
         $display("FAIL ferr_hold: data_out=%h low=%0d want a5/0", data_out, rl_cnt - rl0);
      end
   endtask

   task automatic test_reset_mid;
      int dv0;
      $display("reset during data bit 4");
      tb_low = 1'b1;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         tb_low = (i != 0);
         tick(16);
      end
      tb_low = 1'b1;
      tick(8);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midframe_busy: busy=%b want 1", busy);
      end
      rst    = 1'b1;
      tb_low = 1'b0;
      #1;
      vectors++;
      if (bus_line !== 1'b1 || {data_out, data_valid, frame_err, busy} !== 11'h000) begin
         miscompares++;
         $display("FAIL midframe_reset: line=%b do=%h dv=%b fe=%b busy=%b want 1/00/0/0/0",
                  bus_line, data_out, data_valid, frame_err, busy);
      end
      tick(2);
      rst = 1'b0;
      tick(20);
      dv0 = dv_cnt;
      send_frame(8'h81, 1'b1);
      wait_not_busy(100);
      vectors++;
      if (dv_cnt - dv0 !== 1 || data_out !== 8'h81) begin
         miscompares++;
         $display("FAIL after_reset_81: pulses=%0d data_out=%h want 1/81", dv_cnt - dv0, data_out);
      end
`ifdef ONEWIRE_ACK_EN
      begin
         int n = 0;
         send_frame(8'h77, 1'b1);
         while (bus_line !== 1'b0 && n < 40) begin
            tick(1);
            n++;
         end
         vectors++;
         if (bus_line !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_seen: line=%b want 0", bus_line);
         end
         tick(5);
         $display("reset during ack");
         rst = 1'b1;
         #1;
         vectors++;
         if (bus_line !== 1'b1 || {data_out, data_valid, frame_err, busy} !== 11'h000) begin
            miscompares++;
            $display("FAIL midack_reset: line=%b do=%h dv=%b fe=%b busy=%b want 1/00/0/0/0",
                     bus_line, data_out, data_valid, frame_err, busy);
         end
         tick(2);
         rst = 1'b0;
         tick(20);
         dv0 = dv_cnt;
         send_frame(8'h81, 1'b1);
         wait_not_busy(100);
         vectors++;
         if (dv_cnt - dv0 !== 1 || data_out !== 8'h81) begin
            miscompares++;
            $display("FAIL after_ack_reset_81: pulses=%0d data_out=%h want 1/81", dv_cnt - dv0, data_out);
         end
      end
`endif
   endtask

   task automatic test_back_to_back;
      int dv0 = dv_cnt;
      send_frame(8'h00, 1'b1);
      wait_not_busy(100);
      send_frame(8'hFF, 1'b1);
      wait_not_busy(100);
      vectors++;
      if (dv_cnt - dv0 !== 2 || prev_dv !== 8'h00 || last_dv !== 8'hFF) begin
         miscompares++;
         $display("FAIL back_to_back: pulses=%0d first=%h second=%h want 2/00/ff",
                  dv_cnt - dv0, prev_dv, last_dv);
      end
      vectors++;
      if (both_cnt !== 0 || long_cnt !== 0) begin
         miscompares++;
         $display("FAIL pulse_shape: overlap=%0d long=%0d want 0/0", both_cnt, long_cnt);
      end
   endtask

   task automatic test_lsb_first;
      int dv0 = dv_cnt;
      send_frame(8'h5A, 1'b1);
      wait_not_busy(100);
      vectors++;
      if (dv_cnt - dv0 !== 1 || last_dv !== 8'h5A) begin
         miscompares++;
         $display("FAIL frame_5a: pulses=%0d data=%h want 1/5a", dv_cnt - dv0, last_dv);
      end
      send_frame(8'h1E, 1'b1);
      wait_not_busy(100);
      vectors++;
      if (data_out !== 8'h1E) begin
         miscompares++;
         $display("FAIL frame_1e_order: data_out=%h want 1e", data_out);
      end
`ifdef ONEWIRE_ACK_EN
      vectors++;
      if (rl_cnt == 0) begin
         miscompares++;
         $display("FAIL ack_total: responder low cycles=%0d want nonzero", rl_cnt);
      end
`else
      vectors++;
      if (rl_cnt !== 0) begin
         miscompares++;
         $display("FAIL never_driven: responder low cycles=%0d want 0", rl_cnt);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_frame_a5;
      test_glitch;
      test_frame_err;
      test_reset_mid;
      test_back_to_back;
      test_lsb_first;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1);
   end

endmodule
